// File: rtl/lfsr_victim_arb.sv
// lfsr_victim_arb
// Shared pseudo-random victim-way source for the cache replacement logic.
// One 11-bit LFSR is shared by NREQ requesters through a round-robin req/ack
// handshake. Each grant returns a way index. The index starts at the LFSR's
// low bits and skips ways that the winning requester marks as locked.
//
// Ports
//   clock       system clock
//   reset       synchronous, active-high reset
//   req         per-requester request, held until acked
//   lock_mask   per-requester locked-way mask, slice [i*WAYS +: WAYS]
//   seed_load   load seed_in into the LFSR at this edge (0 -> LFSR_SEED)
//   seed_in     new seed
//   ack         one-hot, single-cycle grant-complete pulse
//   rand_out    selected way, valid while |ack
//   all_locked  valid with ack, every way of the winner was locked
//   busy        high while serving a grant
//
// state | meaning
// IDLE  | waiting for a request; picks the round-robin winner
// SERVE | one-cycle grant: ack, way selection, LFSR advance
module lfsr_victim_arb #(
  parameter int                      NREQ      = 2,
  parameter int                      LFSR_BITS = 11,
  parameter logic [LFSR_BITS-1:0]    LFSR_SEED = 11'd101,
  parameter int                      RAND_BITS = 2,
  parameter bit                      FREE_RUN  = 1'b0
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NREQ-1:0]                   req,
  input  logic [NREQ*(1<<RAND_BITS)-1:0]    lock_mask,
  input  logic                              seed_load,
  input  logic [LFSR_BITS-1:0]              seed_in,
  output logic [NREQ-1:0]                   ack,
  output logic [RAND_BITS-1:0]              rand_out,
  output logic                              all_locked,
  output logic                              busy
);

  localparam int WAYS  = 1 << RAND_BITS;
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t               state_q, state_d;
  logic [LFSR_BITS-1:0] lfsr_q, lfsr_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic [WAYS-1:0]      mask_q, mask_d;

  logic                 req_found;
  logic                 way_found;
  logic [RAND_BITS-1:0] way_pick;
  logic [RAND_BITS-1:0] way_cand;
  logic [LFSR_BITS-1:0] lfsr_next;
  logic                 serve_ok;

  // Two-step form of the core's random-replacement recurrence.
  assign lfsr_next = {lfsr_q[1] ^ lfsr_q[3], lfsr_q[0] ^ lfsr_q[2],
                      lfsr_q[LFSR_BITS-1:2]};

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    win_d     = win_q;
    mask_d    = mask_q;
    req_found = 1'b0;
    case (state_q)
      IDLE: begin
        // Search starts at the requester after the last granted one.
        for (int i = 1; i <= NREQ; i++) begin
          if (!req_found && req[(int'(rr_q) + i) % NREQ]) begin
            req_found = 1'b1;
            win_d     = IDX_W'((int'(rr_q) + i) % NREQ);
          end
        end
        if (req_found) begin
          mask_d  = lock_mask[int'(win_d)*WAYS +: WAYS];
          state_d = SERVE;
        end
      end
      SERVE: begin
        rr_d    = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (seed_load) begin
      lfsr_d = (seed_in == '0) ? LFSR_SEED : seed_in;
    end else if (FREE_RUN || state_q == SERVE) begin
      lfsr_d = lfsr_next;
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // First unlocked way at or after r, wrapping modulo WAYS. If none is
  // free the starting point r is reported unchanged.
  always_comb begin
    way_found = 1'b0;
    way_pick  = lfsr_q[RAND_BITS-1:0];
    way_cand  = '0;
    for (int j = 0; j < WAYS; j++) begin
      way_cand = lfsr_q[RAND_BITS-1:0] + RAND_BITS'(j);
      if (!way_found && !mask_q[way_cand]) begin
        way_found = 1'b1;
        way_pick  = way_cand;
      end
    end
  end

  // A reset arriving in the SERVE cycle aborts the grant, so it also masks
  // the grant outputs of that cycle.
  assign serve_ok = (state_q == SERVE) && !reset;

  always_comb begin
    ack = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (serve_ok && win_q == IDX_W'(k)) ack[k] = 1'b1;
    end
  end

  assign rand_out   = serve_ok ? way_pick : '0;
  assign all_locked = serve_ok && (&mask_q);
  assign busy       = (state_q == SERVE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      rr_q    <= IDX_W'(NREQ - 1);
      win_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      mask_q  <= mask_d;
    end
  end

endmodule

// File: tb/tb_lfsr_victim_arb.sv
// Directed bench for lfsr_victim_arb: one instance in grant-advance mode and
// one in free-running mode, with hand-computed expected values.
module tb_lfsr_victim_arb;

  logic        clock;
  logic        reset, seed_load;
  logic [1:0]  req;
  logic [7:0]  lock_mask;
  logic [10:0] seed_in;
  logic [1:0]  ack;
  logic [1:0]  rand_out;
  logic        all_locked, busy;

  logic        reset_fr;
  logic [1:0]  req_fr;
  logic [1:0]  ack_fr;
  logic [1:0]  rand_fr;
  logic        all_locked_fr, busy_fr;

  int checks = 0;
  int errors = 0;

  lfsr_victim_arb #(.FREE_RUN(1'b0)) u_dut (
    .clock(clock), .reset(reset), .req(req), .lock_mask(lock_mask),
    .seed_load(seed_load), .seed_in(seed_in), .ack(ack), .rand_out(rand_out),
    .all_locked(all_locked), .busy(busy)
  );

  lfsr_victim_arb #(.FREE_RUN(1'b1)) u_fr (
    .clock(clock), .reset(reset_fr), .req(req_fr), .lock_mask(8'h00),
    .seed_load(1'b0), .seed_in(11'd0), .ack(ack_fr), .rand_out(rand_fr),
    .all_locked(all_locked_fr), .busy(busy_fr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic grant0(input logic [3:0] mask, input logic [1:0] exp_way,
                        input logic exp_all, input string tag);
    lock_mask = {4'b0000, mask};
    req = 2'b01;
    tick();
    chk({tag, "_ack"}, 32'(ack), 32'd1);
    chk({tag, "_way"}, 32'(rand_out), 32'(exp_way));
    chk({tag, "_all"}, 32'(all_locked), 32'(exp_all));
    req = 2'b00;
    tick();
  endtask

  task automatic load_seed(input logic [10:0] s);
    seed_in = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  bit seen [2048];
  int dups, zeros, visited;
  logic [10:0] v;

  initial begin
    reset = 1'b1; seed_load = 1'b0; req = 2'b00; lock_mask = 8'h00; seed_in = 11'd0;
    reset_fr = 1'b1; req_fr = 2'b00;
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    chk("rst_ack",  32'(ack), 32'd0);
    chk("rst_rand", 32'(rand_out), 32'd0);
    chk("rst_all",  32'(all_locked), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lfsr", 32'(u_dut.lfsr_q), 32'd101);

    // First grant: r=01, LFSR 101 -> 25, busy for one cycle only.
    req = 2'b01;
    #1;
    chk("no_comb_ack", 32'(ack), 32'd0);
    tick();
    chk("g1_ack",  32'(ack), 32'd1);
    chk("g1_rand", 32'(rand_out), 32'd1);
    chk("g1_busy", 32'(busy), 32'd1);
    req = 2'b00;
    tick();
    chk("g1_ack_off", 32'(ack), 32'd0);
    chk("g1_busy_off", 32'(busy), 32'd0);
    chk("g1_lfsr", 32'(u_dut.lfsr_q), 32'd25);

    // Second grant from requester 1: r=01, LFSR -> 1542.
    req = 2'b10;
    tick();
    chk("g2_ack",  32'(ack), 32'd2);
    chk("g2_rand", 32'(rand_out), 32'd1);
    req = 2'b00;
    tick();
    chk("g2_lfsr", 32'(u_dut.lfsr_q), 32'd1542);

    // Third grant from requester 0: r=10.
    grant0(4'b0000, 2'b10, 1'b0, "g3");
    chk("g3_lfsr", 32'(u_dut.lfsr_q), 32'd1921);

    // Locked-way skipping at r=10.
    load_seed(11'd1542);
    chk("seed_1542", 32'(u_dut.lfsr_q), 32'd1542);
    grant0(4'b0100, 2'b11, 1'b0, "lk2");
    load_seed(11'd1542);
    grant0(4'b1100, 2'b00, 1'b0, "lk23");
    load_seed(11'd1542);
    grant0(4'b1111, 2'b10, 1'b1, "lkall");
    chk("lkall_lfsr", 32'(u_dut.lfsr_q), 32'd1921);

    // Zero seed falls back to LFSR_SEED; seed 7 gives r=11.
    load_seed(11'd0);
    chk("seed_zero", 32'(u_dut.lfsr_q), 32'd101);
    load_seed(11'd7);
    chk("seed_7", 32'(u_dut.lfsr_q), 32'd7);
    grant0(4'b0000, 2'b11, 1'b0, "s7");

    // Both requesters held continuously: 0,1,0,1 on every second cycle.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 2'b11;
    tick(); chk("alt_a0", 32'(ack), 32'd1);
    tick(); chk("alt_gap0", 32'(ack), 32'd0);
    tick(); chk("alt_a1", 32'(ack), 32'd2);
    tick(); chk("alt_gap1", 32'(ack), 32'd0);
    tick(); chk("alt_a2", 32'(ack), 32'd1);
    tick(); chk("alt_gap2", 32'(ack), 32'd0);
    tick(); chk("alt_a3", 32'(ack), 32'd2);
    req = 2'b00;
    tick();

    // Free-running instance: full period over 2047 cycles.
    reset_fr = 1'b0;
    chk("fr_start", 32'(u_fr.lfsr_q), 32'd101);
    dups = 0; zeros = 0; visited = 0;
    for (int n = 0; n < 2048; n++) seen[n] = 1'b0;
    for (int n = 0; n < 2047; n++) begin
      v = u_fr.lfsr_q;
      if (v == 11'd0) zeros++;
      if (seen[v]) dups++;
      else visited++;
      seen[v] = 1'b1;
      tick();
    end
    chk("fr_visited", 32'(visited), 32'd2047);
    chk("fr_dups", 32'(dups), 32'd0);
    chk("fr_zeros", 32'(zeros), 32'd0);
    chk("fr_wrap", 32'(u_fr.lfsr_q), 32'd101);

    // Reset asserted during SERVE aborts the grant.
    req_fr = 2'b01;
    tick();
    req_fr = 2'b00;
    chk("fr_serve_busy", 32'(busy_fr), 32'd1);
    reset_fr = 1'b1;
    #1;
    chk("fr_abort_ack", 32'(ack_fr), 32'd0);
    tick();
    reset_fr = 1'b0;
    chk("fr_abort_lfsr", 32'(u_fr.lfsr_q), 32'd101);
    chk("fr_abort_busy", 32'(busy_fr), 32'd0);
    tick();
    chk("fr_abort_noack", 32'(ack_fr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
